cic_comb_stage: RTL and testbench



---
 rtl/cic_pkg.sv | 10 +
 rtl/cic_delay_line.sv | 30 +++
 rtl/cic_comb_stage.sv | 64 ++++++
 tb/tb_cic_comb_stage.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared CIC definitions: default sample width, default differential delay,
// and the signed sample type used by integrator, comb and decimator blocks.
package cic_pkg;

  localparam int CIC_W = 12;
  localparam int CIC_D = 5;

  typedef logic signed [CIC_W-1:0] cic_sample_t;

endpackage : cic_pkg

// File: rtl/cic_delay_line.sv
// Enabled shift register of D signed samples with synchronous active-high
// clear. dout is the sample written D enabled cycles earlier.
module cic_delay_line
  import cic_pkg::*;
#(
  parameter int W = CIC_W,
  parameter int D = CIC_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] dout
);

  logic signed [W-1:0] d [D];

  // Shift one position per enabled sample; clear on reset (clear wins over en).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < D; k++) d[k] <= '0;
    end else if (en) begin
      d[0] <= din;
      for (int k = 1; k < D; k++) d[k] <= d[k-1];
    end
  end

  assign dout = d[D-1];

endmodule : cic_delay_line

// File: rtl/cic_comb_stage.sv
// Single CIC comb section: y[n] = x[n] - x[n-D], modulo 2^W, one-clock
// latency, advancing only on enabled samples.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W = CIC_W,
  parameter int D = CIC_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [W-1:0] x,
  output logic signed [W-1:0] y,
  output logic                y_valid
);

  // Two's-complement subtraction truncated to W bits; wrap-around is the
  // intended CIC behaviour, the chain gain lives in the integrator width.
  function automatic logic signed [W-1:0] wrap_sub(
    input logic signed [W-1:0] a,
    input logic signed [W-1:0] b
  );
    logic signed [W:0] full;
    full = a - b;
    return full[W-1:0];
  endfunction

  logic signed [W-1:0] x_old_p0;
  logic signed [W-1:0] diff_p0;
  logic signed [W-1:0] y_p1;
  logic                vld_p1;

  cic_delay_line #(
    .W (W),
    .D (D)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .din  (x),
    .dout (x_old_p0)
  );

  assign diff_p0 = wrap_sub(x, x_old_p0);

  // ---- stage p0 -> p1: output register; y holds between strobes ----
  always_ff @(posedge clk) begin
    if (rst) begin
      y_p1 <= '0;
    end else if (en) begin
      y_p1 <= diff_p0;
    end
  end

  // Valid pulses for exactly the cycle following an enabled sample.
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= en;
  end

  assign y       = y_p1;
  assign y_valid = vld_p1;

endmodule : cic_comb_stage

// File: tb/tb_cic_comb_stage.sv
// Self-checking bench for cic_comb_stage: directed test-plan cases plus a
// randomized run, all scored against a sample-history reference model.
module tb_cic_comb_stage;

  localparam int W = 12;
  localparam int D = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic signed [W-1:0] x;
  logic signed [W-1:0] y;
  logic                y_valid;

  int checks   = 0;
  int failures = 0;

  // Reference model state: every enabled sample since the last reset.
  int hist[$];
  int exp_y = 0;
  int exp_v = 0;

  cic_comb_stage #(.W(W), .D(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .x       (x),
    .y       (y),
    .y_valid (y_valid)
  );

  always #5 clk = ~clk;

  function automatic int wrapw(input int v);
    int m;
    m = v & ((1 << W) - 1);
    if (m >= (1 << (W - 1))) m -= (1 << W);
    return m;
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one clock of stimulus, advance the model, compare after the edge.
  task automatic step(input bit r, input bit e, input int xv);
    int n, old;
    rst = r;
    en  = e;
    x   = xv[W-1:0];
    @(posedge clk);
    if (r) begin
      hist.delete();
      exp_y = 0;
      exp_v = 0;
    end else if (e) begin
      n     = hist.size();
      old   = (n >= D) ? hist[n-D] : 0;
      exp_y = wrapw(wrapw(xv) - old);
      hist.push_back(wrapw(xv));
      exp_v = 1;
    end else begin
      exp_v = 0;
    end
    #1;
    check_eq("model_y", int'(y), exp_y);
    check_eq("model_vld", int'(y_valid), exp_v);
  endtask

  initial begin
    int imp_exp[8];
    imp_exp = '{1, 0, 0, 0, 0, -1, 0, 0};
    rst = 1'b1; en = 1'b0; x = '0;

    // Reset held 10 cycles with random input and en=1.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, int'($urandom));
      check_eq("rst_y", int'(y), 0);
      check_eq("rst_vld", int'(y_valid), 0);
    end
    step(1'b0, 1'b0, 0);
    check_eq("post_rst_y", int'(y), 0);
    check_eq("post_rst_vld", int'(y_valid), 0);

    // Impulse with continuous enable.
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, (i == 0) ? 1 : 0);
      check_eq("imp_y", int'(y), imp_exp[i]);
      check_eq("imp_vld", int'(y_valid), 1);
    end

    // Step up then step down.
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 100);
      check_eq("step_up", int'(y), (i < D) ? 100 : 0);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 0);
      check_eq("step_dn", int'(y), (i < D) ? -100 : 0);
    end

    // Gated enable: strobe every 4th clock, impulse of 7.
    step(1'b1, 1'b0, 0);
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0) begin
          step(1'b0, 1'b1, (s == 0) ? 7 : 0);
          check_eq("gate_y", int'(y), (s == 0) ? 7 : ((s == D) ? -7 : 0));
          check_eq("gate_vld", int'(y_valid), 1);
        end else begin
          step(1'b0, 1'b0, int'($urandom));
          check_eq("gate_hold_y", int'(y), (s == 0) ? 7 : ((s == D) ? -7 : 0));
          check_eq("gate_idle_vld", int'(y_valid), 0);
        end
      end
    end

    // Wrap-around in both directions.
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, 1);
    step(1'b0, 1'b1, -2048);
    check_eq("wrap_neg", int'(y), 2047);
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, -1);
    step(1'b0, 1'b1, 2047);
    check_eq("wrap_pos", int'(y), -2048);

    // Reset in the middle of a ramp discards all history.
    step(1'b1, 1'b0, 0);
    for (int i = 1; i <= 10; i++) step(1'b0, 1'b1, i);
    step(1'b1, 1'b1, 55);
    check_eq("midrst_y", int'(y), 0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 3);
      check_eq("midrst_run", int'(y), (i < D) ? 3 : 0);
    end

    // Randomized traffic: random enable gaps, full-range data, rare resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 40) == 0), ($urandom_range(0, 2) != 0),
           int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_cic_comb_stage
